// File: rtl/ag32gbd_capture_sequencer.sv
// Camera frame capture sequencer: pixel stream in, paced BRAM
// write-buffer request windows out, buffer flip on frame commit.
module ag32gbd_capture_sequencer #(
  parameter int FRAME_BYTES = 256,
  parameter int REQ_HIGH    = 4,
  parameter int REQ_LOW     = 4
) (
  input  logic        sys_clock,
  input  logic        resetn,
  input  logic        Enable,
  input  logic        FrameStart,
  input  logic [7:0]  PixelData,
  input  logic        PixelValid,
  output logic        PixelReady,
  output logic [7:0]  BufferWriteData,
  output logic [9:0]  BufferWriteOffset,
  output logic        RequestWriteBuffer,
  output logic        FlipBuffer,
  output logic        FrameDone,
  output logic [15:0] FrameCount,
  output logic        Truncated,
  output logic        Busy
);

  localparam int CMAX = (REQ_HIGH > REQ_LOW) ? REQ_HIGH : REQ_LOW;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    ACCEPT,
    REQ_HI,
    REQ_LO,
    COMMIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_cnt;
  logic [8:0]    r_off;
  logic          r_pend;
  logic [7:0]    r_data;
  logic [8:0]    r_woff;
  logic          r_flip;
  logic [15:0]   r_count;
  logic          r_trunc;

  logic w_hi_last;
  logic w_lo_last;
  logic w_restart;
  logic w_frame_end;
  logic w_in_frame;
  logic w_ready;
  logic w_req;
  logic w_done;
  logic w_busy;

  assign w_hi_last   = (r_cnt == CW'(REQ_HIGH - 1));
  assign w_lo_last   = (r_cnt == CW'(REQ_LOW - 1));
  assign w_restart   = r_pend | FrameStart;
  assign w_frame_end = (r_off == 9'(FRAME_BYTES - 1));
  assign w_in_frame  = (r_state == ACCEPT) ||
                       (r_state == REQ_HI) ||
                       (r_state == REQ_LO);

  // Next-state and state-decoded outputs; restart beats frame end
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_req   = 1'b0;
    w_done  = 1'b0;
    w_busy  = 1'b1;
    unique case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (Enable) w_next = WAIT_SOF;
      end
      WAIT_SOF: begin
        w_busy = 1'b0;
        if (!Enable) w_next = IDLE;
        else if (FrameStart) w_next = ACCEPT;
      end
      ACCEPT: begin
        w_ready = 1'b1;
        if (PixelValid) w_next = REQ_HI;
        else if (!Enable) w_next = IDLE;
      end
      REQ_HI: begin
        w_req = 1'b1;
        if (w_hi_last) w_next = REQ_LO;
      end
      REQ_LO: begin
        if (w_lo_last) begin
          if (!w_restart && w_frame_end) w_next = COMMIT;
          else if (!Enable) w_next = IDLE;
          else w_next = ACCEPT;
        end
      end
      COMMIT: begin
        w_done = 1'b1;
        w_next = Enable ? WAIT_SOF : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge sys_clock) begin
    if (!resetn) r_state <= IDLE;
    else r_state <= w_next;
  end

  // Window timer, restarts on every phase change
  always_ff @(posedge sys_clock) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if ((r_state == REQ_HI && !w_hi_last) ||
                 (r_state == REQ_LO && !w_lo_last)) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // Offset, captured byte, restart flag and frame bookkeeping
  always_ff @(posedge sys_clock) begin
    if (!resetn) begin
      r_off   <= '0;
      r_pend  <= 1'b0;
      r_data  <= '0;
      r_woff  <= '0;
      r_flip  <= 1'b0;
      r_count <= '0;
      r_trunc <= 1'b0;
    end else begin
      if (r_state == IDLE && !Enable) r_trunc <= 1'b0;
      if (FrameStart && w_in_frame) r_trunc <= 1'b1;
      if (r_state == WAIT_SOF) begin
        r_off  <= '0;
        r_pend <= 1'b0;
      end
      if (r_state == ACCEPT) begin
        if (PixelValid) begin
          r_data <= PixelData;
          r_woff <= r_off;
          r_pend <= FrameStart;
        end else if (FrameStart) begin
          r_off <= '0;
        end
      end
      if ((r_state == REQ_HI || r_state == REQ_LO) && FrameStart)
        r_pend <= 1'b1;
      if (r_state == REQ_LO && w_lo_last) begin
        r_pend <= 1'b0;
        if (w_restart) r_off <= '0;
        else if (!w_frame_end) r_off <= r_off + 9'd1;
      end
      if (r_state == COMMIT) begin
        r_flip  <= ~r_flip;
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign PixelReady         = w_ready;
  assign RequestWriteBuffer = w_req;
  assign FrameDone          = w_done;
  assign Busy               = w_busy;
  assign BufferWriteData    = r_data;
  assign BufferWriteOffset  = {1'b0, r_woff};
  assign FlipBuffer         = r_flip;
  assign FrameCount         = r_count;
  assign Truncated          = r_trunc;

endmodule

// File: tb/tb_ag32gbd_capture_sequencer.sv
// Bench for ag32gbd_capture_sequencer: cycle model with countdown
// windows, per-cycle compare, plus literal scenario checks.
module tb_ag32gbd_capture_sequencer;

  localparam int NB = 4;
  localparam int H  = 4;
  localparam int L  = 4;
  localparam int W  = H + L;

  logic        clk = 1'b0;
  logic        resetn;
  logic        Enable;
  logic        FrameStart;
  logic [7:0]  PixelData;
  logic        PixelValid;
  logic        PixelReady;
  logic [7:0]  BufferWriteData;
  logic [9:0]  BufferWriteOffset;
  logic        RequestWriteBuffer;
  logic        FlipBuffer;
  logic        FrameDone;
  logic [15:0] FrameCount;
  logic        Truncated;
  logic        Busy;

  ag32gbd_capture_sequencer #(
    .FRAME_BYTES(NB), .REQ_HIGH(H), .REQ_LOW(L)
  ) dut (
    .sys_clock(clk),
    .resetn(resetn),
    .Enable(Enable),
    .FrameStart(FrameStart),
    .PixelData(PixelData),
    .PixelValid(PixelValid),
    .PixelReady(PixelReady),
    .BufferWriteData(BufferWriteData),
    .BufferWriteOffset(BufferWriteOffset),
    .RequestWriteBuffer(RequestWriteBuffer),
    .FlipBuffer(FlipBuffer),
    .FrameDone(FrameDone),
    .FrameCount(FrameCount),
    .Truncated(Truncated),
    .Busy(Busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string nm, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: run 0=off,1=armed,2=in frame; t = window cycles left
  int  m_run = 0, m_t = 0, m_off = 0, m_woff = 0, m_data = 0;
  int  m_count = 0;
  bit  m_commit = 0, m_pend = 0, m_flip = 0, m_trunc = 0, m_live = 0;

  always @(posedge clk) begin
    m_live = 1;
    if (!resetn) begin
      m_run = 0; m_t = 0; m_off = 0; m_woff = 0; m_data = 0;
      m_count = 0; m_commit = 0; m_pend = 0; m_flip = 0; m_trunc = 0;
    end else if (m_commit) begin
      m_commit = 0;
      m_flip = ~m_flip;
      m_count = (m_count + 1) % 65536;
      m_run = Enable ? 1 : 0;
    end else if (m_run == 0) begin
      if (!Enable) m_trunc = 0;
      else m_run = 1;
    end else if (m_run == 1) begin
      m_off = 0;
      m_pend = 0;
      if (!Enable) m_run = 0;
      else if (FrameStart) m_run = 2;
    end else if (m_t == 0) begin
      if (FrameStart) m_trunc = 1;
      if (PixelValid) begin
        m_data = PixelData;
        m_woff = m_off;
        m_pend = FrameStart;
        m_t = W;
      end else begin
        if (FrameStart) m_off = 0;
        if (!Enable) m_run = 0;
      end
    end else begin
      if (FrameStart) begin
        m_trunc = 1;
        m_pend = 1;
      end
      m_t--;
      if (m_t == 0) begin
        if (m_pend) begin
          m_pend = 0;
          m_off = 0;
          m_run = Enable ? 2 : 0;
        end else if (m_off == NB - 1) begin
          m_commit = 1;
        end else begin
          m_off++;
          m_run = Enable ? 2 : 0;
        end
      end
    end
  end

  // Logs for literal scenario checks
  int lg_off[$], lg_dat[$], lg_cyc[$], lg_flip[$];
  int n_hi = 0, n_done = 0, cyc = 0;
  bit prev_req = 0;

  task automatic clear_logs();
    lg_off.delete(); lg_dat.delete(); lg_cyc.delete(); lg_flip.delete();
    n_hi = 0; n_done = 0;
  endtask

  // Per-cycle compare against model, plus window logging
  always @(negedge clk) begin
    cyc++;
    if (m_live) begin
      check("ready", PixelReady, (m_run == 2 && m_t == 0 && !m_commit));
      check("req", RequestWriteBuffer, (m_t > L));
      check("done", FrameDone, m_commit);
      check("busy", Busy, (m_run == 2 || m_commit));
      check("data", BufferWriteData, m_data);
      check("offset", BufferWriteOffset, m_woff);
      check("flip", FlipBuffer, m_flip);
      check("count", FrameCount, m_count);
      check("trunc", Truncated, m_trunc);
    end
    if (RequestWriteBuffer) n_hi++;
    if (FrameDone) n_done++;
    if (RequestWriteBuffer && !prev_req) begin
      lg_off.push_back(int'(BufferWriteOffset));
      lg_dat.push_back(int'(BufferWriteData));
      lg_cyc.push_back(cyc);
      lg_flip.push_back(int'(FlipBuffer));
    end
    prev_req = RequestWriteBuffer;
  end

  // Pixel source: queue of bytes, optional gap after each accept
  byte unsigned src_q[$];
  int  gap = 0, gapcnt = 0;
  bit  rnd = 0, hs = 0;

  initial begin
    PixelValid = 0;
    PixelData = 0;
    forever begin
      @(negedge clk);
      hs = PixelValid && PixelReady;
      @(posedge clk);
      #1;
      if (hs && src_q.size() > 0) begin
        void'(src_q.pop_front());
        gapcnt = gap;
      end
      if (rnd) begin
        PixelValid = 1'($urandom);
        PixelData = 8'($urandom);
      end else if (gapcnt > 0) begin
        gapcnt--;
        PixelValid = 0;
      end else if (src_q.size() > 0) begin
        PixelValid = 1;
        PixelData = src_q[0];
      end else begin
        PixelValid = 0;
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_sof();
    FrameStart = 1;
    tick();
    FrameStart = 0;
  endtask

  task automatic wait_count(int tgt, int lim);
    int k = 0;
    while (FrameCount != 16'(tgt) && k < lim) begin
      tick();
      k++;
    end
    check("wait_count", FrameCount, tgt);
  endtask

  task automatic wait_win(int off, int lim);
    int k = 0;
    while (!(RequestWriteBuffer && BufferWriteOffset == 10'(off)) && k < lim) begin
      tick();
      k++;
    end
    check("wait_win_timeout", (k < lim), 1);
  endtask

  task automatic push(int first, int n);
    for (int i = 0; i < n; i++) src_q.push_back(8'(first + i));
  endtask

  initial begin
    int exp_off[7];
    resetn = 0;
    Enable = 0;
    FrameStart = 0;
    rnd = 1;

    // 1: reset with random inputs
    repeat (2) begin
      @(posedge clk);
      #1;
      Enable = 1'($urandom);
      FrameStart = 1'($urandom);
    end
    @(negedge clk);
    check("rst_ready", PixelReady, 0);
    check("rst_req", RequestWriteBuffer, 0);
    check("rst_flip", FlipBuffer, 0);
    check("rst_count", FrameCount, 0);
    check("rst_busy", Busy, 0);
    check("rst_offset", BufferWriteOffset, 0);
    check("rst_trunc", Truncated, 0);
    @(posedge clk);
    #1;
    rnd = 0;
    resetn = 1;
    Enable = 0;
    FrameStart = 0;
    tick(2);

    // 2: full frame, always valid
    Enable = 1;
    tick(2);
    clear_logs();
    push(10, 4);
    pulse_sof();
    wait_count(1, 100);
    tick(2);
    check("f1_flip", FlipBuffer, 1);
    check("f1_windows", lg_off.size(), 4);
    for (int i = 0; i < 4 && i < lg_off.size(); i++) begin
      check("f1_off", lg_off[i], i);
      check("f1_dat", lg_dat[i], 10 + i);
      if (i > 0) check("f1_spacing", lg_cyc[i] - lg_cyc[i-1], 9);
    end
    check("f1_req_cycles", n_hi, 16);
    check("f1_done_cycles", n_done, 1);

    // 3: 20-cycle gaps between bytes
    clear_logs();
    gap = 20;
    push(40, 4);
    pulse_sof();
    wait_count(2, 300);
    tick(2);
    gap = 0;
    check("f2_windows", lg_off.size(), 4);
    for (int i = 1; i < 4 && i < lg_off.size(); i++)
      check("f2_spacing", lg_cyc[i] - lg_cyc[i-1], 21);
    check("f2_req_cycles", n_hi, 16);
    check("f2_flip", FlipBuffer, 0);

    // 4: early FrameStart during window of offset 2
    clear_logs();
    push(20, 7);
    pulse_sof();
    wait_win(2, 100);
    pulse_sof();
    wait_count(3, 200);
    tick(2);
    exp_off = '{0, 1, 2, 0, 1, 2, 3};
    check("f3_windows", lg_off.size(), 7);
    for (int i = 0; i < 7 && i < lg_off.size(); i++)
      check("f3_off", lg_off[i], exp_off[i]);
    if (lg_flip.size() > 3) check("f3_noflip", lg_flip[3], 0);
    check("f3_trunc", Truncated, 1);
    check("f3_done_cycles", n_done, 1);
    check("f3_flip", FlipBuffer, 1);

    // 5: Enable drop during window of offset 1
    clear_logs();
    push(60, 4);
    pulse_sof();
    wait_win(1, 100);
    Enable = 0;
    tick(12);
    src_q.delete();
    check("f4_busy", Busy, 0);
    check("f4_req_cycles", n_hi, 8);
    check("f4_flip", FlipBuffer, 1);
    check("f4_count", FrameCount, 3);
    check("f4_trunc_clr", Truncated, 0);

    // 6: two frames, then reset inside third
    Enable = 1;
    tick(2);
    push(80, 4);
    pulse_sof();
    wait_count(4, 100);
    push(90, 4);
    pulse_sof();
    wait_count(5, 100);
    push(100, 4);
    pulse_sof();
    wait_win(0, 100);
    resetn = 0;
    tick();
    check("f5_rst_req", RequestWriteBuffer, 0);
    check("f5_rst_count", FrameCount, 0);
    check("f5_rst_flip", FlipBuffer, 0);
    src_q.delete();
    resetn = 1;
    Enable = 0;
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
